// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states and
// the helper that classifies operations.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_MUL  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;
    localparam logic [3:0] ALU_REMU = 4'b1110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_seqdiv.sv
// Restoring unsigned divider datapath, one quotient bit per step.
// quo_nxt/rem_nxt are the values the registers take on the current step.
module alu_mc_seqdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_nxt,
    output logic [WIDTH-1:0] rem_nxt
);

    logic [WIDTH-1:0] q, r, d;
    logic [WIDTH:0]   trial;

    // Dividend bits shift out of q into r while quotient bits shift into q.
    always_comb begin
        trial = {r, q[WIDTH-1]} - {1'b0, d};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = {r[WIDTH-2:0], q[WIDTH-1]};
            quo_nxt = {q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
            r <= '0;
            d <= '0;
        end else if (start) begin
            q <= dividend;
            r <= '0;
            d <= divisor;
        end else if (step) begin
            q <= quo_nxt;
            r <= rem_nxt;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith/shift ops plus
// iterative unsigned multiply (low word), divide and remainder.
//
// state | meaning
// IDLE  | ready for a new operation
// CALC  | iterating multiply or divide, counter running down
// DONE  | result and flags valid, waiting for out_ready
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       ALUFn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ng,
    output logic             overflow
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] MUL_CYC = CW'(WIDTH / MUL_BITS);
    localparam logic [CW-1:0] DIV_CYC = CW'(WIDTH);

    state_t state, state_n;
    logic [CW-1:0]      cnt;
    logic [3:0]         op_r;
    logic [2*WIDTH-1:0] mcand_sh, acc, partial, acc_n;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   sum, diff, sc_res, fin_res, quo_nxt, rem_nxt;
    logic               sc_ov, fin_ov, accept, go_calc, div_start, div_step;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign go_calc   = accept && ((ALUFn == ALU_MUL) || (is_iterative(ALUFn) && (y != '0)));
    assign div_start = go_calc && (ALUFn != ALU_MUL);
    assign div_step  = (state == CALC) && (op_r != ALU_MUL);
    assign sum       = x + y;
    assign diff      = x - y;

    // Only reached for DIVU/REMU when y==0, which never enters CALC.
    always_comb begin
        sc_res = '0;
        sc_ov  = 1'b0;
        case (ALUFn)
            ALU_AND:  sc_res = x & y;
            ALU_OR:   sc_res = x | y;
            ALU_XOR:  sc_res = x ^ y;
            ALU_ADD: begin
                sc_res = sum;
                sc_ov  = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_res = diff;
                sc_ov  = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
            end
            ALU_SLL:  sc_res = x << y[SW-1:0];
            ALU_SRL:  sc_res = x >> y[SW-1:0];
            ALU_DIVU: sc_res = '1;
            ALU_REMU: sc_res = x;
            default:  sc_res = '0;
        endcase
    end

    always_comb begin
        partial = '0;
        for (int b = 0; b < MUL_BITS; b++) begin
            if (mplier[b]) partial = partial + (mcand_sh << b);
        end
        acc_n = acc + partial;
    end

    always_comb begin
        fin_res = rem_nxt;
        fin_ov  = 1'b0;
        if (op_r == ALU_MUL) begin
            fin_res = acc_n[WIDTH-1:0];
            fin_ov  = (acc_n[2*WIDTH-1:WIDTH] != '0);
        end else if (op_r == ALU_DIVU) begin
            fin_res = quo_nxt;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = go_calc ? CALC : DONE;
            CALC: if (cnt == CW'(1)) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            op_r      <= '0;
            mcand_sh  <= '0;
            mplier    <= '0;
            acc       <= '0;
            out       <= '0;
            zero      <= 1'b0;
            ng        <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_r <= ALUFn;
                    if (go_calc) begin
                        cnt      <= (ALUFn == ALU_MUL) ? MUL_CYC : DIV_CYC;
                        mcand_sh <= {{WIDTH{1'b0}}, x};
                        mplier   <= y;
                        acc      <= '0;
                    end else begin
                        out       <= sc_res;
                        zero      <= (sc_res == '0);
                        ng        <= sc_res[WIDTH-1];
                        overflow  <= sc_ov;
                        out_valid <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (op_r == ALU_MUL) begin
                        acc      <= acc_n;
                        mcand_sh <= mcand_sh << MUL_BITS;
                        mplier   <= mplier >> MUL_BITS;
                    end
                    if (cnt == CW'(1)) begin
                        out       <= fin_res;
                        zero      <= (fin_res == '0);
                        ng        <= fin_res[WIDTH-1];
                        overflow  <= fin_ov;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    alu_mc_seqdiv #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .step     (div_step),
        .dividend (x),
        .divisor  (y),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: one instance with MUL_BITS=1, one with MUL_BITS=4.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_valid4 = 1'b0, out_ready = 1'b1;
    logic [31:0] x = '0, y = '0;
    logic [3:0]  ALUFn = '0;

    logic        in_ready, out_valid, zero, ng, overflow;
    logic [31:0] out;
    logic        in_ready4, out_valid4, zero4, ng4, overflow4;
    logic [31:0] out4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .MUL_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ALUFn(ALUFn), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .ng(ng), .overflow(overflow)
    );

    alu_mc #(.WIDTH(32), .MUL_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .x(x), .y(y), .ALUFn(ALUFn), .out_valid(out_valid4), .out_ready(out_ready),
        .out(out4), .zero(zero4), .ng(ng4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one operation and returns after out_valid is seen (or the bound expires).
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit sel, output int lat);
        @(negedge clk);
        check({tag, "/in_ready"}, {31'b0, sel ? in_ready4 : in_ready}, 32'd1);
        x = a; y = b; ALUFn = op;
        if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid4 = 1'b0;
        lat = 1;
        while (!(sel ? out_valid4 : out_valid) && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic [2:0] f,
                          input int elat, input bit sel);
        int lat;
        issue(tag, op, a, b, sel, lat);
        check({tag, "/lat"}, 32'(lat), 32'(elat));
        check({tag, "/out"}, sel ? out4 : out, r);
        check({tag, "/flags"}, {29'b0, sel ? {zero4, ng4, overflow4} : {zero, ng, overflow}},
              {29'b0, f});
        @(posedge clk); #1;
        check({tag, "/pulse"}, {31'b0, sel ? out_valid4 : out_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int stale;

        repeat (2) @(posedge clk);
        #1;
        check("rst/out_valid", {31'b0, out_valid}, 32'd0);
        check("rst/out", out, 32'd0);
        check("rst/flags", {29'b0, zero, ng, overflow}, 32'd0);
        check("rst/in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("rst/in_ready_rel", {31'b0, in_ready}, 32'd1);

        // flags are {zero, ng, overflow}
        do_vec("add_ovf",  ALU_ADD,  32'h7FFFFFFF, 32'h1,     32'h80000000, 3'b011, 1, 0);
        do_vec("sub",      ALU_SUB,  32'h13,       32'h2,     32'h11,       3'b000, 1, 0);
        do_vec("sub_ovf",  ALU_SUB,  32'h80000000, 32'h1,     32'h7FFFFFFF, 3'b001, 1, 0);
        do_vec("and",      ALU_AND,  32'hF0F0,     32'hFF00,  32'hF000,     3'b000, 1, 0);
        do_vec("or",       ALU_OR,   32'hF0F0,     32'hFF00,  32'hFFF0,     3'b000, 1, 0);
        do_vec("xor",      ALU_XOR,  32'hF0F0,     32'hFF00,  32'h0FF0,     3'b000, 1, 0);
        do_vec("sll",      ALU_SLL,  32'h1,        32'h23,    32'h8,        3'b000, 1, 0);
        do_vec("srl",      ALU_SRL,  32'h10,       32'h3,     32'h2,        3'b000, 1, 0);
        do_vec("illegal",  4'b1111,  32'hAB,       32'hCD,    32'h0,        3'b100, 1, 0);
        do_vec("mul_big",  ALU_MUL,  32'h10000,    32'h10000, 32'h0,        3'b101, 33, 0);
        do_vec("mul_7x6",  ALU_MUL,  32'h7,        32'h6,     32'h2A,       3'b000, 33, 0);
        do_vec("mul_ffff", ALU_MUL,  32'hFFFF,     32'hFFFF,  32'hFFFE0001, 3'b010, 33, 0);
        do_vec("mul4_big", ALU_MUL,  32'h10000,    32'h10000, 32'h0,        3'b101, 9, 1);
        do_vec("mul4_x16", ALU_MUL,  32'h12345678, 32'h10,    32'h23456780, 3'b001, 9, 1);
        do_vec("divu",     ALU_DIVU, 32'd100,      32'd7,     32'd14,       3'b000, 33, 0);
        do_vec("remu",     ALU_REMU, 32'd100,      32'd7,     32'd2,        3'b000, 33, 0);
        do_vec("divu_y0",  ALU_DIVU, 32'd100,      32'd0,     32'hFFFFFFFF, 3'b010, 1, 0);
        do_vec("remu_y0",  ALU_REMU, 32'd100,      32'd0,     32'd100,      3'b000, 1, 0);
        do_vec("divu_max", ALU_DIVU, 32'hFFFFFFFF, 32'h1,     32'hFFFFFFFF, 3'b010, 33, 0);
        do_vec("remu_max", ALU_REMU, 32'hFFFFFFFF, 32'h10,    32'hF,        3'b000, 33, 0);

        // Consumer stalls: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue("hold", ALU_SUB, 32'h13, 32'h2, 0, lat);
        check("hold/lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold/out", out, 32'h11);
            check("hold/flags", {29'b0, zero, ng, overflow}, 32'd0);
            check("hold/valid", {31'b0, out_valid}, 32'd1);
            check("hold/in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold/valid_drop", {31'b0, out_valid}, 32'd0);
        check("hold/in_ready_back", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of a divide abandons it.
        @(negedge clk);
        x = 32'd100; y = 32'd7; ALUFn = ALU_DIVU; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rstmid/busy", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rstmid/valid", {31'b0, out_valid}, 32'd0);
        check("rstmid/out", out, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check("rstmid/in_ready", {31'b0, in_ready}, 32'd1);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("rstmid/no_stale", 32'(stale), 32'd0);
        do_vec("add_after", ALU_ADD, 32'd1, 32'd1, 32'd2, 3'b000, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
